// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, state codes,
// ALU/mux select encodings and the internal control-word layout.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH   = 4'd0;
  localparam state_t S_DECODE  = 4'd1;
  localparam state_t S_MEMADR  = 4'd2;
  localparam state_t S_MEMRD   = 4'd3;
  localparam state_t S_MEMWB   = 4'd4;
  localparam state_t S_MEMWR   = 4'd5;
  localparam state_t S_RTYPEEX = 4'd6;
  localparam state_t S_RTYPEWB = 4'd7;
  localparam state_t S_BEQEX   = 4'd8;
  localparam state_t S_ADDIEX  = 4'd9;
  localparam state_t S_ADDIWB  = 4'd10;
  localparam state_t S_JEX     = 4'd11;
  localparam state_t S_BNEEX   = 4'd12;
  localparam state_t S_ERR     = 4'd13;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegalOp;
  } ctrl_t;

  // States that own the memory port and are therefore watched by the timer.
  function automatic logic isMemState(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath
// plus memory side (slave).
interface multicycle_ctrl_if;

  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       memreq;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       illegal_op;
  logic       bus_err;

  modport master (
    input  op, zero, mem_ready,
    output memreq, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
           aluop, regwrite, regdst, memtoreg, illegal_op, bus_err
  );

  modport slave (
    output op, zero, mem_ready,
    input  memreq, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
           aluop, regwrite, regdst, memtoreg, illegal_op, bus_err
  );

endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Watchdog for memory waits: counts stalled cycles and flags the last one
// that still lacks mem_ready. WAIT_TIMEOUT of 0 disables it.
module mem_wait_timer #(
  parameter int WAIT_TIMEOUT = 15,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_active && !i_ready) begin
      r_count <= r_count + 1'b1;
    end
  end

  generate
    if (WAIT_TIMEOUT == 0) begin : g_off
      assign o_timeout = 1'b0;
    end else begin : g_on
      assign o_timeout = i_active && !i_ready &&
                         (r_count == CNT_W'(WAIT_TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core with memory-ready watchdog.
// Optional bne support is enabled by defining MULTICYCLE_CTRL_BNE_EN.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 15,
  parameter int CNT_W        = 4
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  logic   w_timeout;
  logic   w_en;
`ifdef MULTICYCLE_CTRL_BNE_EN
  logic   w_branchNe;
`endif

  // Leaving any state restarts the count, so each memory state starts at zero.
  mem_wait_timer #(
    .WAIT_TIMEOUT (WAIT_TIMEOUT),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_next != r_state),
    .i_active  (isMemState(r_state)),
    .i_ready   (bus.mem_ready),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_ctrl = '0;
`ifdef MULTICYCLE_CTRL_BNE_EN
    w_branchNe = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        w_ctrl.memreq  = 1'b1;
        w_ctrl.alusrcb = SRCB_FOUR;
        if (bus.mem_ready) begin
          w_ctrl.irwrite = 1'b1;
          w_ctrl.pcwrite = 1'b1;
          w_next         = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_DECODE: begin
        w_ctrl.alusrcb = SRCB_IMM_SH2;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
`ifdef MULTICYCLE_CTRL_BNE_EN
          OP_BNE:       w_next = S_BNEEX;
`endif
          default: begin
            w_ctrl.illegalOp = 1'b1;
            w_next           = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_IMM;
        w_next         = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_ctrl.memreq = 1'b1;
        w_ctrl.iord   = 1'b1;
        if (bus.mem_ready)  w_next = S_MEMWB;
        else if (w_timeout) w_next = S_ERR;
      end
      S_MEMWB: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memtoreg = 1'b1;
        w_next          = S_FETCH;
      end
      S_MEMWR: begin
        w_ctrl.memreq   = 1'b1;
        w_ctrl.memwrite = 1'b1;
        w_ctrl.iord     = 1'b1;
        if (bus.mem_ready)  w_next = S_FETCH;
        else if (w_timeout) w_next = S_ERR;
      end
      S_RTYPEEX: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_REGB;
        w_ctrl.aluop   = ALUOP_FUNCT;
        w_next         = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.regdst   = 1'b1;
        w_next          = S_FETCH;
      end
      S_BEQEX: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.aluop   = ALUOP_SUB;
        w_ctrl.pcsrc   = PCSRC_ALUOUT;
        w_ctrl.branch  = 1'b1;
        w_next         = S_FETCH;
      end
`ifdef MULTICYCLE_CTRL_BNE_EN
      S_BNEEX: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.aluop   = ALUOP_SUB;
        w_ctrl.pcsrc   = PCSRC_ALUOUT;
        w_branchNe     = 1'b1;
        w_next         = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_IMM;
        w_next         = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_ctrl.regwrite = 1'b1;
        w_next          = S_FETCH;
      end
      S_JEX: begin
        w_ctrl.pcsrc   = PCSRC_JUMP;
        w_ctrl.pcwrite = 1'b1;
        w_next         = S_FETCH;
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_FETCH;
    endcase
  end

  // Reset blanks every output so nothing is written in the reset cycle.
  assign w_en = !reset;

  assign bus.memreq     = w_en & w_ctrl.memreq;
  assign bus.memwrite   = w_en & w_ctrl.memwrite;
  assign bus.iord       = w_en & w_ctrl.iord;
  assign bus.irwrite    = w_en & w_ctrl.irwrite;
  assign bus.pcsrc      = w_en ? w_ctrl.pcsrc : PCSRC_ALU;
  assign bus.alusrca    = w_en & w_ctrl.alusrca;
  assign bus.alusrcb    = w_en ? w_ctrl.alusrcb : SRCB_REGB;
  assign bus.aluop      = w_en ? w_ctrl.aluop : ALUOP_ADD;
  assign bus.regwrite   = w_en & w_ctrl.regwrite;
  assign bus.regdst     = w_en & w_ctrl.regdst;
  assign bus.memtoreg   = w_en & w_ctrl.memtoreg;
  assign bus.illegal_op = w_en & w_ctrl.illegalOp;
  assign bus.bus_err    = w_en & (r_state == S_ERR);
`ifdef MULTICYCLE_CTRL_BNE_EN
  assign bus.pcen = w_en & (w_ctrl.pcwrite | (w_ctrl.branch & bus.zero) |
                            (w_branchNe & ~bus.zero));
`else
  assign bus.pcen = w_en & (w_ctrl.pcwrite | (w_ctrl.branch & bus.zero));
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS core.
- Sequences the shared ALU, register file, PC and the unified instruction/data memory port over several cycles per instruction.
- Drives the 2-bit aluop consumed by the ALU function decoder.
- Adds a memory ready handshake with a watchdog timeout.

Parameters:
- WAIT_TIMEOUT, 15: maximum cycles spent waiting for mem_ready in one memory state; 0 disables the watchdog.
- CNT_W, 4: watchdog counter width; must satisfy 2^CNT_W > WAIT_TIMEOUT.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- op  in  6  instruction[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- memreq  out  1  memory access request
- memwrite  out  1  write strobe, qualified by memreq
- iord  out  1  0 = PC address, 1 = ALU-out address
- irwrite  out  1  load the instruction register
- pcen  out  1  PC load enable: pcwrite | (branch & zero)
- pcsrc  out  2  00 ALU result, 01 ALU-out register, 10 jump target
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2
- aluop  out  2  00 add, 01 sub, 10 decode funct
- regwrite  out  1  register file write
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  1 = memory data, 0 = ALU-out
- illegal_op  out  1  one-cycle pulse on an unknown opcode
- bus_err  out  1  sticky watchdog error flag

Behaviour:
- Reset and output model:
  - While reset is high: state = FETCH, watchdog counter = 0, bus_err = 0, and every output is forced to 0.
  - Outputs are Moore-decoded from state. Exceptions: pcen uses zero combinationally; irwrite/pcwrite in FETCH are qualified by mem_ready.
  - Any signal not listed for a state below is 0.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- FETCH:
  - Outputs: memreq=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - When mem_ready=1: irwrite=1, pcwrite=1, next state DECODE. Otherwise hold in FETCH.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=00.
  - Next state by op: lw/sw -> MEMADR, R-type -> RTYPEEX, beq -> BEQEX, addi -> ADDIEX, j -> JEX.
  - Any other op: illegal_op=1 for this cycle, next state FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00; next MEMRD for lw, MEMWR for sw.
- MEMRD: memreq=1, iord=1; hold until mem_ready, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0; next FETCH.
- MEMWR: memreq=1, memwrite=1, iord=1; hold until mem_ready, then FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10; next RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0; next FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00; next ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0; next FETCH.
- JEX: pcsrc=10, pcwrite=1; next FETCH.
- ERR: all outputs 0 except bus_err=1; state is held until reset.
- Latency with mem_ready asserted immediately: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
- Watchdog (memory states FETCH, MEMRD, MEMWR):
  - Counter clears on entry to any memory state.
  - Counter increments each cycle memreq=1 and mem_ready=0.
  - If counter == WAIT_TIMEOUT-1 and mem_ready=0, next state is ERR.
  - mem_ready on the last allowed cycle completes normally; mem_ready wins over timeout in the same cycle.
- mem_ready while memreq=0 is ignored.
- Reset mid-instruction aborts the instruction; no writes occur in the reset cycle.

Optional Feature:
- Macro: MULTICYCLE_CTRL_BNE_EN.
- Defined:
  - op 000101 (bne) moves DECODE -> BNEEX.
  - BNEEX has the BEQEX outputs but asserts branch_ne instead of branch.
  - pcen = pcwrite | (branch & zero) | (branch_ne & ~zero).
- Undefined: 000101 is illegal (illegal_op pulse, return to FETCH), and branch_ne logic is absent.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants;
  - state enum;
  - aluop encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10);
  - alusrcb and pcsrc encodings.
- One sub-module, mem_wait_timer: the watchdog counter, with inputs clear/active/ready and output timeout.

Test Plan:
- lw, mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 in cycle 5 only.
- R-type -> aluop=10 in RTYPEEX; regwrite=1 and regdst=1 in cycle 4.
- beq with zero=1 -> pcen=1 and pcsrc=01 in cycle 3; with zero=0 -> pcen=0.
- WAIT_TIMEOUT=4, mem_ready held 0 in FETCH -> ERR entered after 4 cycles, bus_err=1 sticky; reset clears it.
- sw with mem_ready arriving on the 4th waiting cycle (WAIT_TIMEOUT=4) -> completes normally with no ERR; then op=111111 -> illegal_op pulse, return to FETCH.
- Reset asserted during MEMRD -> all outputs 0; FETCH with memreq=1 on the cycle after reset drops.
